// File: rtl/sraml_axi_pkg.sv
// Shared definitions for the data-side SRAM-like to AXI3 bridge.
//   state_e    : bridge FSM states
//   SIZE_*     : SRAM-like transfer size encodings
//   wstrb_gen  : byte-strobe generation from transfer size and address[1:0]
package sraml_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_WR_RESP = 3'd4
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Size 3 is not a legal SRAM-like size; it falls into the word case.
    function automatic logic [3:0] wstrb_gen(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << addr_lo;
            SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/d_sraml2axi.sv
// Data-side bridge: SRAM-like master -> AXI3 master subset, one outstanding
// transaction at a time.
//
// Optional feature: define DATA_ADDR_MAP_EN to fold kseg0/kseg1 addresses
// (addr[31:29] = 100 / 101) down to physical {3'b000, addr[28:0]}. Without
// it, addresses pass straight through.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   data_req/wr/size/addr/wdata SRAM-like request side
//   data_rdata/addr_ok/data_ok  SRAM-like response side
//   ar*, r*                     AXI read address / read data channels
//   aw*, w*, b*                 AXI write address / write data / response
module d_sraml2axi
    import sraml_axi_pkg::*;
#(
    parameter int AXI_DW = 32,   // only 32 supported
    parameter int AXI_AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [AXI_AW-1:0] data_addr,
    input  logic [AXI_DW-1:0] data_wdata,
    output logic [AXI_DW-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [AXI_AW-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [AXI_DW-1:0] rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [AXI_AW-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [AXI_DW-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    state_e              state_q, state_d;
    logic [AXI_AW-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic [AXI_DW-1:0]   wdata_q, wdata_d;
    logic [AXI_DW-1:0]   rdata_q, rdata_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                data_ok_q, data_ok_d;
    logic                aw_fin, w_fin;
    logic [AXI_AW-1:0]   axi_addr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            data_ok_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            data_ok_q <= data_ok_d;
        end
    end

    // Next state and datapath updates. The read/write direction is captured
    // by the branch taken out of IDLE, so it needs no register of its own.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        data_ok_d = 1'b0;
        aw_fin    = aw_done_q | awready;
        w_fin     = w_done_q | wready;
        case (state_q)
            ST_IDLE: if (data_req) begin
                addr_d    = data_addr;
                size_d    = data_size;
                wdata_d   = data_wdata;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = data_wr ? ST_WR : ST_RD_ADDR;
            end
            ST_RD_ADDR: if (arready) state_d = ST_RD_DATA;
            ST_RD_DATA: if (rvalid) begin
                rdata_d   = rdata;
                data_ok_d = 1'b1;
                state_d   = ST_IDLE;
            end
            // AW and W complete independently; leave only when both have.
            ST_WR: begin
                if (aw_fin && w_fin) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_RESP;
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
            ST_WR_RESP: if (bvalid) begin
                data_ok_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address presented on AR/AW
    always_comb begin
`ifdef DATA_ADDR_MAP_EN
        if (addr_q[AXI_AW-1 -: 3] == 3'b100 || addr_q[AXI_AW-1 -: 3] == 3'b101)
            axi_addr = {3'b000, addr_q[AXI_AW-4:0]};
        else
            axi_addr = addr_q;
`else
        axi_addr = addr_q;
`endif
    end

    // Outputs
    always_comb begin
        data_addr_ok = (state_q == ST_IDLE) && data_req;
        data_data_ok = data_ok_q;
        data_rdata   = rdata_q;
        araddr       = axi_addr;
        arsize       = {1'b0, size_q};
        arvalid      = (state_q == ST_RD_ADDR);
        rready       = (state_q == ST_RD_DATA);
        awaddr       = axi_addr;
        awsize       = {1'b0, size_q};
        awvalid      = (state_q == ST_WR) && !aw_done_q;
        wdata        = wdata_q;
        wstrb        = wstrb_gen(size_q, addr_q[1:0]);
        wvalid       = (state_q == ST_WR) && !w_done_q;
        bready       = (state_q == ST_WR_RESP);
    end

endmodule

// File: tb/tb_d_sraml2axi.sv
module tb_d_sraml2axi;

    logic        clk, rst;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    d_sraml2axi #(.AXI_DW(32), .AXI_AW(32)) dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected AXI address for a CPU address
    function automatic logic [31:0] map_addr(input logic [31:0] a);
`ifdef DATA_ADDR_MAP_EN
        if (a[31:29] == 3'b100 || a[31:29] == 3'b101) return {3'b000, a[28:0]};
`endif
        return a;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'b0001 << a[1:0];
        if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // Slave memory model, word granular; unwritten words read a pattern.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (mem.exists(k)) return mem[k];
        return k ^ 32'hA5A5_5A5A;
    endfunction

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [31:0] exp_addr_map;
        logic [3:0]  exp_strb;
    } vec_t;
    vec_t vecs [12];

    function automatic logic [2:0] rand_top();
        case ($urandom_range(0, 3))
            0: return 3'b000;
            1: return 3'b100;
            2: return 3'b101;
            default: return 3'b110;
        endcase
    endfunction

    // Random-phase model state
    logic        busy, need_ar, rd_pend, need_aw, need_w, b_pend, done_next, done_rd;
    logic        aw_hs, w_hs;
    logic [31:0] cur_addr, cur_wdata, exp_rdata, last_rdata, ea, k;
    logic [1:0]  cur_size;
    logic [3:0]  st;
    int          stall;

    initial begin
        rst = 1'b1; data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;

        vecs[0]  = '{0, 2'd2, 32'h1FC0_0004, 32'hDEAD_BEEF, 32'h1FC0_0004, 32'h1FC0_0004, 4'b1111};
        vecs[1]  = '{1, 2'd1, 32'h0000_1002, 32'h1234_0000, 32'h0000_1002, 32'h0000_1002, 4'b1100};
        vecs[2]  = '{1, 2'd2, 32'h0000_1000, 32'hCAFE_BABE, 32'h0000_1000, 32'h0000_1000, 4'b1111};
        vecs[3]  = '{1, 2'd0, 32'h0000_1003, 32'h5600_0000, 32'h0000_1003, 32'h0000_1003, 4'b1000};
        vecs[4]  = '{1, 2'd0, 32'h0000_1001, 32'h0000_7800, 32'h0000_1001, 32'h0000_1001, 4'b0010};
        vecs[5]  = '{1, 2'd1, 32'h0000_1000, 32'h0000_9ABC, 32'h0000_1000, 32'h0000_1000, 4'b0011};
        vecs[6]  = '{1, 2'd3, 32'h0000_1004, 32'h1111_2222, 32'h0000_1004, 32'h0000_1004, 4'b1111};
        vecs[7]  = '{0, 2'd2, 32'hBFC0_0000, 32'h0BAD_F00D, 32'hBFC0_0000, 32'h1FC0_0000, 4'b1111};
        vecs[8]  = '{0, 2'd0, 32'hA000_0010, 32'h0000_00EE, 32'hA000_0010, 32'h0000_0010, 4'b0001};
        vecs[9]  = '{0, 2'd2, 32'h9FC0_0000, 32'h7777_8888, 32'h9FC0_0000, 32'h1FC0_0000, 4'b1111};
        vecs[10] = '{0, 2'd1, 32'hC000_0002, 32'h3333_4444, 32'hC000_0002, 32'hC000_0002, 4'b1100};
        vecs[11] = '{1, 2'd2, 32'h8000_0008, 32'h5555_6666, 32'h8000_0008, 32'h0000_0008, 4'b1111};

        // Reset state
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready",  rready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid",  wvalid, 0);
        chk("rst_bready",  bready, 0);
        chk("rst_data_ok", data_data_ok, 0);
        chk("rst_rdata",   data_rdata, 0);
        chk("rst_addr_ok", data_addr_ok, 0);

        // Table: all slave handshakes immediate -> accept c0, AR/AW+W c1, R/B c2, data_ok c3
        for (int i = 0; i < 12; i++) begin
            tick();
            data_req = 1; data_wr = vecs[i].wr; data_size = vecs[i].size;
            data_addr = vecs[i].addr; data_wdata = vecs[i].data; rdata = vecs[i].data;
            arready = 1; awready = 1; wready = 1; rvalid = 1; bvalid = 1;
            #1;
            chk("vec_addr_ok", data_addr_ok, 1);
            tick();
            data_req = 0;
            #1;
`ifdef DATA_ADDR_MAP_EN
            ea = vecs[i].exp_addr_map;
`else
            ea = vecs[i].exp_addr;
`endif
            if (vecs[i].wr) begin
                chk("vec_awvalid", awvalid, 1);
                chk("vec_wvalid",  wvalid, 1);
                chk("vec_awaddr",  awaddr, ea);
                chk("vec_awsize",  awsize, {1'b0, vecs[i].size});
                chk("vec_wstrb",   wstrb, vecs[i].exp_strb);
                chk("vec_wdata",   wdata, vecs[i].data);
            end else begin
                chk("vec_arvalid", arvalid, 1);
                chk("vec_araddr",  araddr, ea);
                chk("vec_arsize",  arsize, {1'b0, vecs[i].size});
            end
            chk("vec_early_ok", data_data_ok, 0);
            tick(); #1;
            if (vecs[i].wr) chk("vec_bready", bready, 1);
            else            chk("vec_rready", rready, 1);
            chk("vec_c2_ok", data_data_ok, 0);
            tick(); #1;
            chk("vec_data_ok", data_data_ok, 1);
            if (!vecs[i].wr) chk("vec_rdata", data_rdata, vecs[i].data);
        end

        // Byte write, awready three cycles late, wready immediate
        tick();
        data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h0000_0012; data_wdata = 32'h00AB_0000;
        awready = 0; wready = 1; bvalid = 0; arready = 0; rvalid = 0;
        #1; chk("bw_addr_ok", data_addr_ok, 1);
        tick(); data_req = 0; #1;
        chk("bw_wstrb", wstrb, 4'b0100);
        chk("bw_wvalid_c1", wvalid, 1);
        chk("bw_awvalid_c1", awvalid, 1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            if (c == 4) awready = 1;
            #1;
            chk("bw_awvalid_held", awvalid, 1);
            chk("bw_wvalid_dropped", wvalid, 0);
            chk("bw_no_bready", bready, 0);
        end
        chk("bw_awaddr", awaddr, 32'h0000_0012);
        tick(); awready = 0; #1;
        chk("bw_bready", bready, 1);
        chk("bw_awvalid_done", awvalid, 0);
        tick(); bvalid = 1; #1;
        chk("bw_ok_wait", data_data_ok, 0);
        tick(); bvalid = 0; #1;
        chk("bw_data_ok", data_data_ok, 1);
        tick(); #1;
        chk("bw_ok_pulse", data_data_ok, 0);

        // Back-to-back: second request held during a busy read
        tick();
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_0040;
        arready = 1; rvalid = 0; awready = 1; wready = 1; bvalid = 0;
        #1; chk("b2b_acc0", data_addr_ok, 1);
        tick(); data_wr = 1; data_addr = 32'h0000_0044; data_wdata = 32'h1234_5678;
        #1; chk("b2b_busy1", data_addr_ok, 0);
        tick(); #1;
        chk("b2b_busy2", data_addr_ok, 0);
        chk("b2b_rready", rready, 1);
        tick(); rvalid = 1; rdata = 32'hCAFE_F00D;
        #1; chk("b2b_busy3", data_addr_ok, 0);
        tick(); rvalid = 0; #1;
        chk("b2b_data_ok", data_data_ok, 1);
        chk("b2b_acc1", data_addr_ok, 1);
        chk("b2b_rdata", data_rdata, 32'hCAFE_F00D);
        tick(); data_req = 0; #1;
        chk("b2b_awvalid", awvalid, 1);
        chk("b2b_awaddr", awaddr, 32'h0000_0044);
        tick(); bvalid = 1; #1;
        chk("b2b_bready", bready, 1);
        tick(); bvalid = 0; #1;
        chk("b2b_data_ok2", data_data_ok, 1);
        chk("b2b_rdata_hold", data_rdata, 32'hCAFE_F00D);

        // Reset while in RD_DATA
        tick();
        data_req = 1; data_wr = 0; data_addr = 32'h0000_0080; arready = 1; rvalid = 0;
        #1;
        tick(); data_req = 0; #1;
        tick(); #1;
        chk("rr_rready", rready, 1);
        rst = 1; rvalid = 1; rdata = 32'h1111_1111;
        tick(); rst = 0; rvalid = 0; #1;
        chk("rr_rready0", rready, 0);
        chk("rr_arvalid0", arvalid, 0);
        chk("rr_awvalid0", awvalid, 0);
        chk("rr_wvalid0", wvalid, 0);
        chk("rr_bready0", bready, 0);
        chk("rr_no_ok", data_data_ok, 0);
        chk("rr_rdata0", data_rdata, 0);
        data_req = 1; #1;
        chk("rr_idle", data_addr_ok, 1);
        data_req = 0;
        tick(); #1;
        chk("rr_no_ok2", data_data_ok, 0);

        // Randomized traffic against a transaction-level model
        busy = 0; need_ar = 0; rd_pend = 0; need_aw = 0; need_w = 0; b_pend = 0;
        done_next = 0; done_rd = 0; last_rdata = 0; stall = 0;
        cur_addr = 0; cur_wdata = 0; cur_size = 0; exp_rdata = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            data_req = ($urandom_range(0, 2) != 0);
            data_wr = 1'($urandom_range(0, 1));
            data_size = 2'($urandom_range(0, 3));
            data_addr = {rand_top(), 19'h0, 10'($urandom)};
            data_wdata = $urandom;
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready = 1'($urandom_range(0, 1));
            rvalid = rd_pend && ($urandom_range(0, 1) == 1);
            rdata = rd_pend ? mem_rd(cur_addr) : $urandom;
            bvalid = b_pend && ($urandom_range(0, 1) == 1);
            #1;
            chk("rnd_data_ok", data_data_ok, done_next);
            if (done_next && done_rd) last_rdata = exp_rdata;
            chk("rnd_rdata", data_rdata, last_rdata);
            if (done_next) busy = 0;
            done_next = 0;

            chk("rnd_rready", rready, rd_pend);
            if (rd_pend && rvalid) begin
                rd_pend = 0; done_next = 1; done_rd = 1; exp_rdata = mem_rd(cur_addr);
            end
            chk("rnd_arvalid", arvalid, need_ar);
            if (need_ar && arready) begin
                chk("rnd_araddr", araddr, cur_addr);
                chk("rnd_arsize", arsize, {1'b0, cur_size});
                need_ar = 0; rd_pend = 1;
            end

            chk("rnd_bready", bready, b_pend);
            if (b_pend && bvalid) begin
                b_pend = 0; done_next = 1; done_rd = 0;
            end
            chk("rnd_awvalid", awvalid, need_aw);
            chk("rnd_wvalid", wvalid, need_w);
            aw_hs = need_aw && awready;
            w_hs = need_w && wready;
            if (aw_hs) begin
                chk("rnd_awaddr", awaddr, cur_addr);
                chk("rnd_awsize", awsize, {1'b0, cur_size});
            end
            if (w_hs) begin
                st = exp_strb(cur_size, cur_addr);
                chk("rnd_wstrb", wstrb, st);
                chk("rnd_wdata", wdata, cur_wdata);
                k = mem_rd(cur_addr);
                for (int b = 0; b < 4; b++)
                    if (st[b]) k[b*8 +: 8] = cur_wdata[b*8 +: 8];
                mem[{cur_addr[31:2], 2'b00}] = k;
            end
            if (aw_hs || w_hs) begin
                if (aw_hs) need_aw = 0;
                if (w_hs) need_w = 0;
                if (!need_aw && !need_w) b_pend = 1;
            end

            chk("rnd_addr_ok", data_addr_ok, data_req && !busy);
            if (data_req && !busy) begin
                busy = 1;
                cur_addr = map_addr(data_addr);
                cur_size = data_size;
                cur_wdata = data_wdata;
                if (data_wr) begin need_aw = 1; need_w = 1; end
                else need_ar = 1;
            end

            if (busy) stall++;
            else stall = 0;
            if (stall > 100) begin
                errors++;
                $display("FAIL rnd_timeout: transaction open for %0d cycles, expected completion", stall);
                break;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
